// File: rtl/pipeline_hazard_control_if.sv
// Control bundle between the ID-stage hazard controller and the IF/IF_ID/ID_EX logic.
// Optional StallCount signal exists only when HAZARD_STALL_COUNT_EN is defined.
interface pipeline_hazard_control_if;
   logic [19:0] ID_Instruction;
   logic        PC_Hold;
   logic        IF_ID_Hold;
   logic        IF_ID_Flush;
   logic        ID_EX_Bubble;
   logic        JumpEnable;
   logic [19:0] JumpAddress;
   logic        StallError;
`ifdef HAZARD_STALL_COUNT_EN
   logic [15:0] StallCount;
`endif

   modport master (
      output ID_Instruction,
      input  PC_Hold, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble,
      input  JumpEnable, JumpAddress, StallError
`ifdef HAZARD_STALL_COUNT_EN
      , input StallCount
`endif
   );

   modport slave (
      input  ID_Instruction,
      output PC_Hold, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble,
      output JumpEnable, JumpAddress, StallError
`ifdef HAZARD_STALL_COUNT_EN
      , output StallCount
`endif
   );
endinterface

// File: rtl/pipeline_hazard_control.sv
// Stall/jump controller for a forwarding-free 5-stage pipeline with a 3-entry destination scoreboard.
// Define HAZARD_STALL_COUNT_EN to add the 16-bit total stall-cycle counter output.
module pipeline_hazard_control #(
   parameter logic [19:0] NOP_INSTR = 20'hF0000,
   parameter logic [3:0]  OP_LOAD   = 4'b1011,
   parameter logic [3:0]  OP_STORE  = 4'b1100,
   parameter logic [3:0]  OP_JUMP   = 4'b1101,
   parameter int          MAX_STALL = 3
) (
   input logic                      Clock,
   input logic                      Reset,
   pipeline_hazard_control_if.slave hc
);
   localparam int CW = $clog2(MAX_STALL + 2);
   localparam logic [CW-1:0] STALL_LIMIT = CW'(MAX_STALL + 1);
   localparam logic [3:0] OP_NOT = 4'b0011;

   typedef enum logic [1:0] {RUN = 2'b00, FLUSH = 2'b01} state_t;

   state_t          state;
   logic [2:0][4:0] sbReg;
   logic [CW-1:0]   stallCnt;
   logic            stallErr;

   logic [3:0] opcode, rd, rs, rt;
   logic       isAlu, isLoad, isStore, isJump, writer;
   logic [3:0] srcA, srcB;
   logic       srcAValid, srcBValid;
   logic [2:0] matchVec;
   logic       hazard, stall, jumpTake, issue;

   assign opcode = hc.ID_Instruction[19:16];
   assign rd     = hc.ID_Instruction[15:12];
   assign rs     = hc.ID_Instruction[11:8];
   assign rt     = hc.ID_Instruction[7:4];

   always_comb begin
      isAlu     = (opcode[3:2] == 2'b00);
      isLoad    = (opcode == OP_LOAD);
      isStore   = (opcode == OP_STORE);
      isJump    = (opcode == OP_JUMP);
      writer    = isAlu | isLoad;
      srcA      = rs;
      srcB      = rt;
      srcAValid = isAlu | isLoad;
      srcBValid = isAlu & (opcode != OP_NOT);
      // Stores read their data register from the rd field
      if (isStore) begin
         srcA      = rd;
         srcB      = rs;
         srcAValid = 1'b1;
         srcBValid = 1'b1;
      end
   end

   // No write-through in the register file, so a WB-stage match still stalls
   for (genvar gi = 0; gi < 3; gi++) begin : g_match
      assign matchVec[gi] = sbReg[gi][4] &&
                            ((srcAValid && (srcA == sbReg[gi][3:0])) ||
                             (srcBValid && (srcB == sbReg[gi][3:0])));
   end

   assign hazard   = |matchVec;
   assign stall    = (state == RUN) && hazard;
   assign jumpTake = (state == RUN) && !hazard && isJump;
   assign issue    = (state == RUN) && !hazard;

   assign hc.PC_Hold      = Reset & stall;
   assign hc.IF_ID_Hold   = Reset & stall;
   assign hc.ID_EX_Bubble = Reset & (stall | (state == FLUSH));
   assign hc.IF_ID_Flush  = Reset & jumpTake;
   assign hc.JumpEnable   = Reset & jumpTake;
   assign hc.JumpAddress  = {4'b0000, hc.ID_Instruction[15:0]};
   assign hc.StallError   = stallErr;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state    <= RUN;
         sbReg    <= '0;
         stallCnt <= '0;
         stallErr <= 1'b0;
      end else begin
         sbReg[2] <= sbReg[1];
         sbReg[1] <= sbReg[0];
         sbReg[0] <= issue ? {writer, rd} : 5'b0;

         case (state)
            RUN:     state <= jumpTake ? FLUSH : RUN;
            FLUSH:   state <= RUN;
            default: state <= RUN;
         endcase

         if (stall) begin
            if (stallCnt != STALL_LIMIT) stallCnt <= stallCnt + 1'b1;
            if (stallCnt == STALL_LIMIT - 1'b1) stallErr <= 1'b1;
         end else begin
            stallCnt <= '0;
         end
      end
   end

`ifdef HAZARD_STALL_COUNT_EN
   logic [15:0] stallTotal;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)     stallTotal <= '0;
      else if (stall) stallTotal <= stallTotal + 16'd1;
   end

   assign hc.StallCount = stallTotal;
`endif
endmodule
